// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: double-buffered stereo frames serialised MSB first, slaved to codec BCLK/DACLRCK.
// Define I2S_TX_ROUND_EN for round-half-up with positive saturation; the default build truncates.
module i2s_dac_tx #(
    parameter int SAMPLE_W    = 32,
    parameter int OUT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLOCK_50,
    input  logic                rst_n,
    input  logic                tick,
    input  logic [SAMPLE_W-1:0] in_L,
    input  logic [SAMPLE_W-1:0] in_R,
    input  logic                AUD_BCLK,
    input  logic                AUD_DACLRCK,
    output logic                AUD_DACDAT,
    output logic                frame_start,
    output logic                underrun,
    output logic                overrun,
    output logic [15:0]         err_count
);
    localparam int               CNT_W = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0] BITS  = CNT_W'(OUT_W);
    localparam int               SHIFT = SAMPLE_W - OUT_W;

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    function automatic logic [OUT_W-1:0] fmt(input logic [SAMPLE_W-1:0] x);
`ifdef I2S_TX_ROUND_EN
        logic [SAMPLE_W:0] sum;
        sum = {x[SAMPLE_W-1], x} + ((SAMPLE_W+1)'(1) << (SHIFT - 1));
        // Only a non-negative input can carry into the sign bit.
        if (!x[SAMPLE_W-1] && sum[SAMPLE_W-1])
            return {1'b0, {(OUT_W-1){1'b1}}};
        return OUT_W'(sum >> SHIFT);
`else
        return OUT_W'(x >> SHIFT);
`endif
    endfunction

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync;
    logic                   bclk_d, lrck_d;
    logic                   bclk_s, lrck_s;
    logic                   bfall, lfall, lrise, shift_en;

    assign bclk_s   = bclk_sync[SYNC_STAGES-1];
    assign lrck_s   = lrck_sync[SYNC_STAGES-1];
    assign bfall    = bclk_d & ~bclk_s;
    assign lfall    = lrck_d & ~lrck_s;
    assign lrise    = ~lrck_d & lrck_s;
    assign shift_en = bfall & ~lrise;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_d    <= 1'b0;
            lrck_d    <= 1'b0;
        end else begin
            bclk_sync <= (bclk_sync << 1) | SYNC_STAGES'(AUD_BCLK);
            lrck_sync <= (lrck_sync << 1) | SYNC_STAGES'(AUD_DACLRCK);
            bclk_d    <= bclk_s;
            lrck_d    <= lrck_s;
        end
    end

    state_t              state, state_nxt;
    logic [SAMPLE_W-1:0] pend_L, pend_R, pend_L_nxt, pend_R_nxt;
    logic [SAMPLE_W-1:0] act_L, act_R, act_L_nxt, act_R_nxt;
    logic                pend_valid, pend_valid_nxt;
    logic [OUT_W-1:0]    shreg, shreg_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic                dacdat_nxt, frame_start_nxt, underrun_nxt, overrun_nxt;
    logic [16:0]         err_sum;
    logic [15:0]         err_nxt;

    // NOTE: every *_nxt is given its default first, so this block can never infer a latch.
    always_comb begin
        state_nxt       = state;
        pend_L_nxt      = pend_L;
        pend_R_nxt      = pend_R;
        pend_valid_nxt  = pend_valid;
        act_L_nxt       = act_L;
        act_R_nxt       = act_R;
        shreg_nxt       = shreg;
        bit_cnt_nxt     = bit_cnt;
        dacdat_nxt      = AUD_DACDAT;
        frame_start_nxt = 1'b0;
        underrun_nxt    = 1'b0;
        overrun_nxt     = 1'b0;

        if (lfall) begin
            // Frame boundary from any state; a fall seen in LEFT resyncs.
            frame_start_nxt = 1'b1;
            if (pend_valid) begin
                act_L_nxt      = pend_L;
                act_R_nxt      = pend_R;
                pend_valid_nxt = 1'b0;
            end else begin
                underrun_nxt = 1'b1;
            end
            shreg_nxt   = fmt(act_L_nxt);
            bit_cnt_nxt = '0;
            dacdat_nxt  = 1'b0;
            state_nxt   = LEFT;
        end else begin
            case (state)
                IDLE: dacdat_nxt = 1'b0;
                LEFT: begin
                    if (lrise) begin
                        shreg_nxt   = fmt(act_R);
                        bit_cnt_nxt = '0;
                        dacdat_nxt  = 1'b0;
                        state_nxt   = RIGHT;
                    end else if (shift_en) begin
                        if (bit_cnt < BITS) begin
                            dacdat_nxt  = shreg[OUT_W-1];
                            shreg_nxt   = shreg << 1;
                            bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        end else begin
                            dacdat_nxt = 1'b0;
                        end
                    end
                end
                RIGHT: begin
                    if (shift_en) begin
                        if (bit_cnt < BITS) begin
                            dacdat_nxt  = shreg[OUT_W-1];
                            shreg_nxt   = shreg << 1;
                            bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        end else begin
                            dacdat_nxt = 1'b0;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Checked after LOAD so a same-cycle tick only overruns if the old sample survived.
        if (tick) begin
            overrun_nxt    = pend_valid_nxt;
            pend_L_nxt     = in_L;
            pend_R_nxt     = in_R;
            pend_valid_nxt = 1'b1;
        end

        err_sum = {1'b0, err_count} + {16'b0, underrun_nxt} + {16'b0, overrun_nxt};
        err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pend_L      <= '0;
            pend_R      <= '0;
            pend_valid  <= 1'b0;
            act_L       <= '0;
            act_R       <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            AUD_DACDAT  <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            overrun     <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            pend_L      <= pend_L_nxt;
            pend_R      <= pend_R_nxt;
            pend_valid  <= pend_valid_nxt;
            act_L       <= act_L_nxt;
            act_R       <= act_R_nxt;
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            AUD_DACDAT  <= dacdat_nxt;
            frame_start <= frame_start_nxt;
            underrun    <= underrun_nxt;
            overrun     <= overrun_nxt;
            err_count   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Randomised self-checking bench for i2s_dac_tx: a cycle-driven codec master plus a frame-level
// reference model of the double buffer; honours I2S_TX_ROUND_EN the same way the design does.
`timescale 1ns/1ps
module tb_i2s_dac_tx;
    localparam int OUT_W    = 24;
    localparam int FRAME    = 1024;
    localparam int HALF     = 512;
    localparam int BPER     = 16;
    localparam int N_FRAMES = 14;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [31:0] in_L = '0;
    logic [31:0] in_R = '0;
    logic        AUD_BCLK = 1'b0;
    logic        AUD_DACLRCK = 1'b0;
    logic        AUD_DACDAT;
    logic        frame_start, underrun, overrun;
    logic [15:0] err_count;

    i2s_dac_tx dut (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .tick        (tick),
        .in_L        (in_L),
        .in_R        (in_R),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .frame_start (frame_start),
        .underrun    (underrun),
        .overrun     (overrun),
        .err_count   (err_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output word as the codec should see it: the sample scaled down by 2^8.
    function automatic logic [23:0] ref_fmt(input logic [31:0] x);
        longint v;
        v = longint'($signed(x));
`ifdef I2S_TX_ROUND_EN
        v = (v + 128) >>> 8;
        if (v > 8388607) v = 8388607;
`else
        v = v >>> 8;
`endif
        return v[23:0];
    endfunction

    typedef struct {
        int          p;
        logic [31:0] l;
        logic [31:0] r;
    } tick_t;

    tick_t plan[$];

    task automatic add_tick(input int p, input logic [31:0] l, input logic [31:0] r);
        tick_t t;
        t.p = p;
        t.l = l;
        t.r = r;
        plan.push_back(t);
    endtask

    // Reference model state
    bit          m_active;
    bit          m_pv;
    logic [31:0] m_pL, m_pR, m_aL, m_aR;
    logic [23:0] m_wL, m_wR;
    int          m_err;
    int          e_fs, e_ur, e_or;
    int          o_fs, o_ur, o_or;

    task automatic model_reset();
        m_active = 0; m_pv = 0;
        m_pL = '0; m_pR = '0; m_aL = '0; m_aR = '0;
        m_wL = '0; m_wR = '0; m_err = 0;
        e_fs = 0; e_ur = 0; e_or = 0;
        o_fs = 0; o_ur = 0; o_or = 0;
    endtask

    task automatic model_load();
        e_fs++;
        if (m_pv) begin
            m_aL = m_pL;
            m_aR = m_pR;
            m_pv = 0;
        end else begin
            e_ur++;
            if (m_err < 65535) m_err++;
        end
        m_wL = ref_fmt(m_aL);
        m_wR = ref_fmt(m_aR);
        m_active = 1;
    endtask

    task automatic model_tick(input logic [31:0] l, input logic [31:0] r);
        if (m_pv) begin
            e_or++;
            if (m_err < 65535) m_err++;
        end
        m_pL = l;
        m_pR = r;
        m_pv = 1;
    endtask

    initial begin
        model_reset();
        for (int n = 0; n < N_FRAMES * FRAME; n++) begin
            int          f, p, bi, nt;
            logic [23:0] w;
            logic        exp_bit;
            @(posedge CLOCK_50);
            #1;
            f = n / FRAME;
            p = n % FRAME;

            // ---- observe ----
            if (n == 5) begin
                check("rst_dacdat", 32'(AUD_DACDAT), 32'd0);
                check("rst_frame_start", 32'(frame_start), 32'd0);
                check("rst_underrun", 32'(underrun), 32'd0);
                check("rst_overrun", 32'(overrun), 32'd0);
                check("rst_err_count", 32'(err_count), 32'd0);
            end
            if (frame_start) o_fs++;
            if (underrun) o_ur++;
            if (overrun) o_or++;

            if (!rst_n && f == 4 && (p % 32) == 0) begin
                check($sformatf("f%0d_inrst_dacdat_p%0d", f, p), 32'(AUD_DACDAT), 32'd0);
                check($sformatf("f%0d_inrst_err_p%0d", f, p), 32'(err_count), 32'd0);
            end

            if ((p % BPER) == BPER / 2) begin
                bi = (p % HALF) / BPER + 1;
                w  = (p >= HALF) ? m_wR : m_wL;
                exp_bit = (m_active && bi >= 2 && bi <= OUT_W + 1) ? w[OUT_W + 1 - bi] : 1'b0;
                check($sformatf("f%0d_%s_bclk%0d", f, (p >= HALF) ? "R" : "L", bi),
                      32'(AUD_DACDAT), 32'(exp_bit));
            end

            if (p == FRAME - 1) begin
                check($sformatf("f%0d_frame_start_cnt", f), 32'(o_fs), 32'(e_fs));
                check($sformatf("f%0d_underrun_cnt", f), 32'(o_ur), 32'(e_ur));
                check($sformatf("f%0d_overrun_cnt", f), 32'(o_or), 32'(e_or));
                check($sformatf("f%0d_err_count", f), 32'(err_count), 32'(m_err));
                o_fs = 0; o_ur = 0; o_or = 0;
                e_fs = 0; e_ur = 0; e_or = 0;
            end

            // ---- reset schedule (mid-frame reset at the 10th BCLK of frame 4's left half) ----
            if (n == 10) rst_n = 1'b1;
            if (f == 4 && p == 150) begin
                rst_n = 1'b0;
                model_reset();
            end
            if (f == 4 && p == 300) rst_n = 1'b1;

            // ---- per-frame tick plan ----
            if (p == 0) begin
                plan.delete();
                case (f)
                    0: add_tick(600, {24'hA5A5A5, 8'($urandom)}, {24'h3C3C3C, 8'($urandom)});
                    4: add_tick(400, $urandom, $urandom);
                    5: begin
                        add_tick(200, $urandom, $urandom);
                        add_tick(700, $urandom, $urandom);
                    end
                    7: add_tick(2, $urandom, $urandom);
                    8: add_tick(300, 32'h00000180, 32'h7FFFFFFF);
                    default: begin
                        if (f >= 9 && f <= N_FRAMES - 2) begin
                            nt = int'($urandom_range(0, 2));
                            if (nt == 1) add_tick(int'($urandom_range(0, 1000)), $urandom, $urandom);
                            if (nt == 2) begin
                                add_tick(int'($urandom_range(0, 500)), $urandom, $urandom);
                                add_tick(int'($urandom_range(501, 1000)), $urandom, $urandom);
                            end
                        end
                    end
                endcase
            end

            // LOAD for the lfall driven at p=0 lands together with a tick driven at p=2.
            if (p == 2 && f >= 1 && rst_n) model_load();

            if (plan.size() > 0 && plan[0].p == p) begin
                tick = 1'b1;
                in_L = plan[0].l;
                in_R = plan[0].r;
                model_tick(plan[0].l, plan[0].r);
                void'(plan.pop_front());
            end else begin
                tick = 1'b0;
                in_L = $urandom;
                in_R = $urandom;
            end

            // ---- codec master: BCLK falls at p%16==0, LRCK changes on those falls ----
            AUD_BCLK    = (p % BPER) >= BPER / 2;
            AUD_DACLRCK = p >= HALF;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
